// File: rtl/power_seq_pkg.sv
// Shared types and defaults for the power-domain sequencer.
// Holds the per-domain state encoding and the default timing constants.
package power_seq_pkg;

    typedef enum logic [2:0] {
        ST_ON          = 3'd0,
        ST_ISO_SET     = 3'd1,
        ST_SW_OFF_WAIT = 3'd2,
        ST_OFF         = 3'd3,
        ST_SW_ON_WAIT  = 3'd4,
        ST_ISO_CLR     = 3'd5,
        ST_RST_REL     = 3'd6
    } pwr_state_e;

    localparam int ISO_CYCLES_DEF     = 4;
    localparam int RST_CYCLES_DEF     = 4;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/power_domain_fsm.sv
// One domain's power sequencing FSM with its shared step/wait counter
// and sticky ack-timeout flag.
// Ports: clk_i, rst_i (sync, active high), on_req_i, ack_i (already
// synchronous), clr_timeout_i; outputs switch_o, iso_o, dom_rst_o,
// status_on_o, busy_o, timeout_o (all registered).
module power_domain_fsm
    import power_seq_pkg::*;
#(
    parameter int ISO_CYCLES     = ISO_CYCLES_DEF,
    parameter int RST_CYCLES     = RST_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic on_req_i,
    input  logic ack_i,
    input  logic clr_timeout_i,
    output logic switch_o,
    output logic iso_o,
    output logic dom_rst_o,
    output logic status_on_o,
    output logic busy_o,
    output logic timeout_o
);

    localparam int CNT_MAX = max3(ISO_CYCLES, RST_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYCLES);

    pwr_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             timeout_nxt;
    logic             sw_d, iso_d, rst_d, stat_d, busy_d;

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_nxt = timeout_o;
        if (clr_timeout_i) begin
            timeout_nxt = 1'b0;
        end
        unique case (state)
            ST_ON: begin
                if (!on_req_i) begin
                    state_nxt = ST_ISO_SET;
                    cnt_nxt   = '0;
                end
            end
            ST_ISO_SET: begin
                if (cnt == ISO_LAST) begin
                    state_nxt = ST_SW_OFF_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_SW_OFF_WAIT: begin
                if (!ack_i) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else if (cnt != TO_MAX) begin
                    // Flag only on the cycle the count arrives, so a clear
                    // issued later in a long wait is not overridden.
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TO_MAX) begin
                        timeout_nxt = 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (on_req_i) begin
                    state_nxt = ST_SW_ON_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_SW_ON_WAIT: begin
                if (ack_i) begin
                    state_nxt = ST_ISO_CLR;
                    cnt_nxt   = '0;
                end else if (cnt != TO_MAX) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == TO_MAX) begin
                        timeout_nxt = 1'b1;
                    end
                end
            end
            ST_ISO_CLR: begin
                if (cnt == ISO_LAST) begin
                    state_nxt = ST_RST_REL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_RST_REL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_ON;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each
    // output changes on the same edge that enters the state.
    always_comb begin
        sw_d   = 1'b1;
        iso_d  = 1'b1;
        rst_d  = 1'b1;
        stat_d = 1'b0;
        busy_d = 1'b1;
        unique case (state_nxt)
            ST_ON: begin
                iso_d  = 1'b0;
                rst_d  = 1'b0;
                stat_d = 1'b1;
                busy_d = 1'b0;
            end
            ST_SW_OFF_WAIT: sw_d = 1'b0;
            ST_OFF: begin
                sw_d   = 1'b0;
                busy_d = 1'b0;
            end
            ST_RST_REL: iso_d = 1'b0;
            default: begin
                sw_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_ON;
            cnt         <= '0;
            timeout_o   <= 1'b0;
            switch_o    <= 1'b1;
            iso_o       <= 1'b0;
            dom_rst_o   <= 1'b0;
            status_on_o <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            timeout_o   <= timeout_nxt;
            switch_o    <= sw_d;
            iso_o       <= iso_d;
            dom_rst_o   <= rst_d;
            status_on_o <= stat_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: rtl/power_domain_sequencer.sv
// Power-gating initiator: one sequencing FSM per domain driving switch,
// isolation and domain reset in a safe order with ack timeout detection.
// Ports: clk_i, rst_i (sync, active high), on_req_i, switch_ack_i,
// clr_timeout_i in; switch_o, iso_o, dom_rst_o, status_on_o, busy_o,
// timeout_o out; all vectors are NUM_DOMAINS wide.
// Macro PWR_SEQ_ACK_SYNC_EN: adds a 2-flop ack synchronizer (reset 1).
module power_domain_sequencer
    import power_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 1,
    parameter int ISO_CYCLES     = ISO_CYCLES_DEF,
    parameter int RST_CYCLES     = RST_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_DOMAINS-1:0] on_req_i,
    output logic [NUM_DOMAINS-1:0] switch_o,
    input  logic [NUM_DOMAINS-1:0] switch_ack_i,
    output logic [NUM_DOMAINS-1:0] iso_o,
    output logic [NUM_DOMAINS-1:0] dom_rst_o,
    output logic [NUM_DOMAINS-1:0] status_on_o,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [NUM_DOMAINS-1:0] timeout_o,
    input  logic [NUM_DOMAINS-1:0] clr_timeout_i
);

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        logic ack;

`ifdef PWR_SEQ_ACK_SYNC_EN
        // Reset to 1 to match the powered switch state after reset.
        logic [1:0] ack_sync;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ack_sync <= 2'b11;
            end else begin
                ack_sync <= {ack_sync[0], switch_ack_i[g]};
            end
        end
        assign ack = ack_sync[1];
`else
        assign ack = switch_ack_i[g];
`endif

        power_domain_fsm #(
            .ISO_CYCLES     (ISO_CYCLES),
            .RST_CYCLES     (RST_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_fsm (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .on_req_i      (on_req_i[g]),
            .ack_i         (ack),
            .clr_timeout_i (clr_timeout_i[g]),
            .switch_o      (switch_o[g]),
            .iso_o         (iso_o[g]),
            .dom_rst_o     (dom_rst_o[g]),
            .status_on_o   (status_on_o[g]),
            .busy_o        (busy_o[g]),
            .timeout_o     (timeout_o[g])
        );
    end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Self-checking bench for power_domain_sequencer (single domain).
// Ack model: switch_ack = switch delayed 15 cycles, optionally forced.
module tb_power_domain_sequencer;

`ifdef PWR_SEQ_ACK_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    localparam int SW   = 0;
    localparam int ISO  = 1;
    localparam int DRST = 2;
    localparam int STAT = 3;
    localparam int BUSY = 4;
    localparam int TMO  = 5;

    typedef struct {
        int    at;
        int    sig;
        logic  val;
        string name;
    } exp_t;

    logic clk = 1'b0;
    logic rst, on_req, clr;
    logic sw, ack, iso, drst, stat, busy, tmo;
    logic force_en, force_val;
    logic [14:0] dly;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   toggles = 0;
    logic sw_prev = 1'b1;
    exp_t q[$];

    power_domain_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .on_req_i      (on_req),
        .switch_o      (sw),
        .switch_ack_i  (ack),
        .iso_o         (iso),
        .dom_rst_o     (drst),
        .status_on_o   (stat),
        .busy_o        (busy),
        .timeout_o     (tmo),
        .clr_timeout_i (clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) dly <= '1;
        else     dly <= {dly[13:0], sw};
    end
    assign ack = force_en ? force_val : dly[14];

    always @(negedge clk) begin
        if (!rst && sw !== sw_prev) toggles++;
        sw_prev = sw;
    end

    function automatic logic pick(input int s);
        case (s)
            SW:      return sw;
            ISO:     return iso;
            DRST:    return drst;
            STAT:    return stat;
            BUSY:    return busy;
            TMO:     return tmo;
            default: return 1'bx;
        endcase
    endfunction

    task automatic push(input int at, input int s, input logic v,
                        input string nm);
        exp_t e;
        e.at = at; e.sig = s; e.val = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        logic obs;
        int   c;
        rst = 1'b1; on_req = 1'b1; clr = 1'b0;
        force_en = 1'b0; force_val = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c = cyc;
        push(c, SW, 1'b1, "rst_switch");
        push(c, ISO, 1'b0, "rst_iso");
        push(c, DRST, 1'b0, "rst_domrst");
        push(c, STAT, 1'b1, "rst_status");
        push(c, BUSY, 1'b0, "rst_busy");
        push(c, TMO, 1'b0, "rst_timeout");
        push(c + 4, BUSY, 1'b0, "rst_hold_busy");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
    endtask

    task automatic test_power_down();
        exp_t e;
        logic obs;
        int   c;
        c = cyc;
        on_req = 1'b0;
        push(c, ISO, 1'b0, "dn_iso_pre");
        push(c + 1, ISO, 1'b1, "dn_iso_set");
        push(c + 1, DRST, 1'b1, "dn_domrst_set");
        push(c + 1, STAT, 1'b0, "dn_status");
        push(c + 1, BUSY, 1'b1, "dn_busy_start");
        push(c + 4, SW, 1'b1, "dn_switch_hold");
        push(c + 5, SW, 1'b0, "dn_switch_off");
        push(c + 12, BUSY, 1'b1, "dn_busy_mid");
        push(c + 20 + S, BUSY, 1'b1, "dn_busy_last");
        push(c + 21 + S, BUSY, 1'b0, "dn_off_busy");
        push(c + 21 + S, SW, 1'b0, "dn_off_switch");
        push(c + 21 + S, ISO, 1'b1, "dn_off_iso");
        push(c + 21 + S, TMO, 1'b0, "dn_off_timeout");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
    endtask

    task automatic test_power_up();
        exp_t e;
        logic obs;
        int   c;
        c = cyc;
        on_req = 1'b1;
        push(c, SW, 1'b0, "up_switch_pre");
        push(c + 1, SW, 1'b1, "up_switch_on");
        push(c + 1, BUSY, 1'b1, "up_busy");
        push(c + 20 + S, ISO, 1'b1, "up_iso_hold");
        push(c + 21 + S, ISO, 1'b0, "up_iso_clr");
        push(c + 21 + S, DRST, 1'b1, "up_domrst_hold");
        push(c + 24 + S, DRST, 1'b1, "up_domrst_last");
        push(c + 24 + S, STAT, 1'b0, "up_status_pre");
        push(c + 25 + S, DRST, 1'b0, "up_domrst_rel");
        push(c + 25 + S, STAT, 1'b1, "up_status_on");
        push(c + 25 + S, BUSY, 1'b0, "up_busy_done");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic obs;
        int   c;
        int   r;
        force_en = 1'b1; force_val = 1'b1;
        c = cyc;
        on_req = 1'b0;
        push(c + 5, SW, 1'b0, "to_switch_off");
        push(c + 68, TMO, 1'b0, "to_before");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
        // clear pulse coincides with the setting edge: set must win
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        push(c + 69, TMO, 1'b1, "to_set_priority");
        push(c + 100, TMO, 1'b1, "to_sticky");
        push(c + 100, BUSY, 1'b1, "to_still_wait");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
        r = cyc;
        force_val = 1'b0;
        push(r + S, BUSY, 1'b1, "to_late_wait");
        push(r + 1 + S, BUSY, 1'b0, "to_late_off");
        push(r + 1 + S, TMO, 1'b1, "to_off_sticky");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
        force_en = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        push(cyc, TMO, 1'b0, "to_cleared");
        push(cyc + 5, TMO, 1'b0, "to_stays_clear");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
    endtask

    task automatic test_pulse();
        exp_t e;
        logic obs;
        int   c;
        int   t0;
        c = cyc;
        t0 = toggles;
        on_req = 1'b0;
        @(negedge clk);
        on_req = 1'b1;
        push(c + 1, ISO, 1'b1, "pl_iso_set");
        push(c + 5, SW, 1'b0, "pl_switch_off");
        push(c + 21 + S, SW, 1'b0, "pl_off_switch");
        push(c + 21 + S, BUSY, 1'b0, "pl_off_busy");
        push(c + 22 + S, SW, 1'b1, "pl_switch_on");
        push(c + 22 + S, BUSY, 1'b1, "pl_up_busy");
        push(c + 45 + 2 * S, STAT, 1'b0, "pl_status_pre");
        push(c + 46 + 2 * S, STAT, 1'b1, "pl_status_on");
        push(c + 46 + 2 * S, BUSY, 1'b0, "pl_busy_done");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
        checks++;
        if (toggles - t0 !== 2) begin
            errors++;
            $display("FAIL pl_switch_edges: got %0d expected 2",
                     toggles - t0);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic obs;
        int   c;
        c = cyc;
        on_req = 1'b0;
        push(c + 8, SW, 1'b0, "rm_in_wait");
        push(c + 8, BUSY, 1'b1, "rm_busy");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        on_req = 1'b1;
        push(c + 9, SW, 1'b1, "rm_switch");
        push(c + 9, ISO, 1'b0, "rm_iso");
        push(c + 9, DRST, 1'b0, "rm_domrst");
        push(c + 9, STAT, 1'b1, "rm_status");
        push(c + 9, BUSY, 1'b0, "rm_busy_clr");
        push(c + 9, TMO, 1'b0, "rm_timeout");
        push(c + 14, STAT, 1'b1, "rm_stays_on");
        while (q.size() > 0) begin
            e = q.pop_front();
            to_cycle(e.at);
            obs = pick(e.sig);
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s @cyc %0d: got %b expected %b",
                         e.name, cyc, obs, e.val);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_down();
        test_power_up();
        test_timeout();
        test_power_up();
        test_pulse();
        test_reset_mid();
        test_power_down();
        test_power_up();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
